// File: rtl/decode_stage.sv
// Decode stage: register file, immediate extender, control decoder, load-use
// stall, branch-shadow squash and the ID/EX pipeline register feeding execute.
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 15,
  parameter int INSTR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]   PCD,
  input  logic [PC_W-1:0]   PCPlus1D,
  input  logic              PCSrcE,
  input  logic              RegWriteW,
  input  logic [3:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              StallD,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemtoRegE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [PC_W-1:0]   PCE,
  output logic [PC_W-1:0]   PCPlus1E,
  output logic [3:0]        RdE,
  output logic [3:0]        Rs1E,
  output logic [3:0]        Rs2E
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR  = 4'h4, OP_SLT = 4'h5, OP_ADDI = 4'h6, OP_LW = 4'h7,
    OP_SW   = 4'h8, OP_BEQ = 4'h9, OP_JMP  = 4'hA
  } opcode_e;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              memto_reg;
    logic              branch;
    logic              jump;
    logic              alu_src;
    logic [2:0]        alu_control;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus1;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
  } idex_t;

  logic [DATA_W-1:0] regs [16];
  logic              kill_d;
  logic              dec_valid;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              hz;
  idex_t             dec;
  idex_t             idex;

  logic [DATA_W-1:0] imm8_sext;
  logic [DATA_W-1:0] imm12_sext;
  logic [3:0]        op;

  assign op         = InstrD[19:16];
  assign imm8_sext  = {{(DATA_W-8){InstrD[7]}}, InstrD[7:0]};
  assign imm12_sext = {{(DATA_W-12){InstrD[11]}}, InstrD[11:0]};

  always_comb begin
    dec       = '0;
    dec_valid = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        dec_valid       = 1'b1;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_control = op[2:0];
        dec.rd          = InstrD[15:12];
        dec.rs1         = InstrD[11:8];
        dec.rs2         = InstrD[7:4];
      end
      OP_ADDI, OP_LW: begin
        dec_valid     = 1'b1;
        uses_rs1      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.memto_reg = (op == OP_LW);
        dec.imm       = imm8_sext;
        dec.rd        = InstrD[15:12];
        dec.rs1       = InstrD[11:8];
      end
      // SW and BEQ both read their second operand from the rd field.
      OP_SW, OP_BEQ: begin
        dec_valid       = 1'b1;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        dec.mem_write   = (op == OP_SW);
        dec.alu_src     = (op == OP_SW);
        dec.branch      = (op == OP_BEQ);
        dec.alu_control = (op == OP_BEQ) ? 3'd1 : 3'd0;
        dec.imm         = imm8_sext;
        dec.rs1         = InstrD[11:8];
        dec.rs2         = InstrD[15:12];
      end
      OP_JMP: begin
        dec_valid = 1'b1;
        dec.jump  = 1'b1;
        dec.imm   = imm12_sext;
      end
      default: dec_valid = 1'b0;
    endcase

    dec.pc       = PCD;
    dec.pc_plus1 = PCPlus1D;
    // Reads bypass the array when writeback targets the same register this cycle.
    if (dec.rs1 == 4'd0)
      dec.rd1 = '0;
    else if (RegWriteW && RdW == dec.rs1)
      dec.rd1 = ResultW;
    else
      dec.rd1 = regs[dec.rs1];
    if (dec.rs2 == 4'd0)
      dec.rd2 = '0;
    else if (RegWriteW && RdW == dec.rs2)
      dec.rd2 = ResultW;
    else
      dec.rd2 = regs[dec.rs2];
  end

  assign hz = MemtoRegE && (RdE != 4'd0) &&
              ((uses_rs1 && dec.rs1 == RdE) || (uses_rs2 && dec.rs2 == RdE));
  assign StallD = hz && !PCSrcE && !kill_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= '0;
    end else if (RegWriteW && RdW != 4'd0) begin
      regs[RdW] <= ResultW;
    end
  end

  // The instruction fetched in the cycle a branch resolves is wrong-path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      kill_d <= 1'b0;
    else
      kill_d <= PCSrcE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idex <= '0;
    else if (PCSrcE || kill_d || StallD || !dec_valid)
      idex <= '0;
    else
      idex <= dec;
  end

  assign RegWriteE   = idex.reg_write;
  assign MemWriteE   = idex.mem_write;
  assign MemtoRegE   = idex.memto_reg;
  assign BranchE     = idex.branch;
  assign JumpE       = idex.jump;
  assign ALUSrcE     = idex.alu_src;
  assign ALUControlE = idex.alu_control;
  assign RD1E        = idex.rd1;
  assign RD2E        = idex.rd2;
  assign ImmExtE     = idex.imm;
  assign PCE         = idex.pc;
  assign PCPlus1E    = idex.pc_plus1;
  assign RdE         = idex.rd;
  assign Rs1E        = idex.rs1;
  assign Rs2E        = idex.rs2;

endmodule
